// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, start/busy/done handshake.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (truncating division).
module seq_divider #(
  parameter int unsigned BUS_SIZE = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [BUS_SIZE-1:0] dividend,
  input  logic [BUS_SIZE-1:0] divisor,
  output logic                busy,
  output logic                done,
  output logic [BUS_SIZE-1:0] quotient,
  output logic [BUS_SIZE-1:0] remainder,
  output logic                div_by_zero
);

  localparam int unsigned W  = BUS_SIZE;
  localparam int unsigned RW = BUS_SIZE + 1;
  localparam int unsigned CW = $clog2(BUS_SIZE + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q;
  logic [W-1:0]    q_q;
  logic [W-1:0]    r_q;
  logic [W-1:0]    dvs_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic            done_q;
  logic [W-1:0]    quo_q;
  logic [W-1:0]    rem_q;
  logic            dbz_q;

  logic [RW-1:0]   r_shift;
  logic [RW-1:0]   sub_b;
  logic [RW:0]     carry;
  logic [W-1:0]    t_diff;
  logic            no_borrow;
  logic [W-1:0]    r_d;
  logic [W-1:0]    q_d;
  logic [CW-1:0]   cnt_d;
  logic            last_c;

  logic [W-1:0]    dnd_mag;
  logic [W-1:0]    dvs_mag;
  logic [W-1:0]    quo_fin;
  logic [W-1:0]    rem_fin;

  // One iteration: shift in the next dividend bit, ripple-subtract the divisor.
  // The stored remainder is always below the divisor, so only the shifted form needs RW bits.
  always_comb begin
    r_shift = {r_q, q_q[W-1]};
    sub_b   = ~{1'b0, dvs_q};
    carry   = '0;
    carry[0] = 1'b1;
    t_diff  = '0;
    for (int i = 0; i < RW; i++) begin
      carry[i+1] = (r_shift[i] & sub_b[i]) | (carry[i] & (r_shift[i] ^ sub_b[i]));
    end
    for (int i = 0; i < W; i++) begin
      t_diff[i] = r_shift[i] ^ sub_b[i] ^ carry[i];
    end
    no_borrow = carry[RW];
    r_d       = no_borrow ? t_diff : r_shift[W-1:0];
    q_d       = {q_q[W-2:0], no_borrow};
    cnt_d     = cnt_q + CW'(1);
    last_c    = (cnt_d == CW'(BUS_SIZE));
  end

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_q_q;
  logic neg_r_q;

  // Core sees magnitudes; signs are re-applied when the result is captured.
  always_comb begin
    dnd_mag = dividend[W-1] ? (~dividend + W'(1)) : dividend;
    dvs_mag = divisor[W-1]  ? (~divisor + W'(1))  : divisor;
    quo_fin = neg_q_q ? (~q_d + W'(1)) : q_d;
    rem_fin = neg_r_q ? (~r_d + W'(1)) : r_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else if (state_q == IDLE && start && divisor != '0) begin
      neg_q_q <= dividend[W-1] ^ divisor[W-1];
      neg_r_q <= dividend[W-1];
    end
  end
`else
  always_comb begin
    dnd_mag = dividend;
    dvs_mag = divisor;
    quo_fin = q_d;
    rem_fin = r_d;
  end
`endif

  // Control FSM; results are written only on the transition into DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quo_q   <= '1;
              rem_q   <= dividend;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              q_q     <= dnd_mag;
              dvs_q   <= dvs_mag;
              r_q     <= '0;
              cnt_q   <= '0;
              dbz_q   <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          q_q   <= q_d;
          r_q   <= r_d;
          cnt_q <= cnt_d;
          if (last_c) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            quo_q   <= quo_fin;
            rem_q   <= rem_fin;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expected results queued at issue, checked on done.
module tb_seq_divider;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  seq_divider #(.BUS_SIZE(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time expired");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every done pops one expected result
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done: done=1 with no pending request");
      end else begin
        e = sb.pop_front();
        n_total++;
        if (quotient !== e.q) $display("FAIL quotient: got %0h expected %0h", quotient, e.q);
        else n_pass++;
        n_total++;
        if (remainder !== e.r) $display("FAIL remainder: got %0h expected %0h", remainder, e.r);
        else n_pass++;
        n_total++;
        if (div_by_zero !== e.dbz) $display("FAIL div_by_zero: got %0b expected %0b", div_by_zero, e.dbz);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL busy_with_done: got %0b expected 0", busy);
        else n_pass++;
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] eq,
                       input logic [W-1:0] er, input logic edbz, input bit push, input bit hold);
    int n = 0;
    @(negedge clk);
    while ((busy || done) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy || done) begin
      n_total++;
      $display("FAIL issue_idle: busy=%0b done=%0b expected idle", busy, done);
    end
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (push) sb.push_back(exp_t'{eq, er, edbz});
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // k counts negedges after the accepting edge, starting at 0
  task automatic wait_done(output int k_done, output int nbusy);
    k_done = -1;
    nbusy  = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        k_done = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0)
      $display("FAIL reset_outputs: got b=%0b d=%0b q=%0h r=%0h z=%0b expected all 0",
               busy, done, quotient, remainder, div_by_zero);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int kd, nb;
    issue(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 1'b1, 1'b0);
    wait_done(kd, nb);
    n_total++;
    if (nb !== 8) $display("FAIL basic_busy_cycles: got %0d expected 8", nb);
    else n_pass++;
    n_total++;
    if (kd !== 8) $display("FAIL basic_latency: got %0d expected 8", kd);
    else n_pass++;
  endtask

  task automatic test_unsigned_cases();
    logic [W-1:0] ta [3] = '{8'd255, 8'd3,   8'd200};
    logic [W-1:0] tb [3] = '{8'd1,   8'd200, 8'd128};
    logic [W-1:0] tq [3] = '{8'd255, 8'd0,   8'd1};
    logic [W-1:0] tr [3] = '{8'd0,   8'd3,   8'd72};
    int kd, nb;
    for (int i = 0; i < 3; i++) begin
      issue(ta[i], tb[i], tq[i], tr[i], 1'b0, 1'b1, 1'b0);
      wait_done(kd, nb);
      n_total++;
      if (kd !== 8) $display("FAIL unsigned_latency[%0d]: got %0d expected 8", i, kd);
      else n_pass++;
    end
  endtask

  task automatic test_signed();
    logic [W-1:0] ta [3] = '{8'hF9, 8'h07, 8'h80};
    logic [W-1:0] tb [3] = '{8'h02, 8'hFE, 8'hFF};
    logic [W-1:0] tq [3] = '{8'hFD, 8'hFD, 8'h80};
    logic [W-1:0] tr [3] = '{8'hFF, 8'h01, 8'h00};
    int kd, nb;
    for (int i = 0; i < 3; i++) begin
      issue(ta[i], tb[i], tq[i], tr[i], 1'b0, 1'b1, 1'b0);
      wait_done(kd, nb);
      n_total++;
      if (kd !== 8) $display("FAIL signed_latency[%0d]: got %0d expected 8", i, kd);
      else n_pass++;
    end
  endtask

  task automatic test_div_by_zero();
    int kd, nb;
    issue(8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 1'b1, 1'b0);
    wait_done(kd, nb);
    n_total++;
    if (kd !== 0) $display("FAIL dbz_latency: got %0d expected 0", kd);
    else n_pass++;
    n_total++;
    if (nb !== 0) $display("FAIL dbz_busy: got %0d busy cycles expected 0", nb);
    else n_pass++;
  endtask

  task automatic test_ignored_start();
    int kd = -1;
    issue(8'd100, 8'd9, 8'd11, 8'd1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        kd = k;
        break;
      end
      if (k == 2) begin
        dividend = 8'd50;
        divisor  = 8'd5;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    n_total++;
    if (kd !== 8) $display("FAIL ignored_start_latency: got %0d expected 8", kd);
    else n_pass++;
    repeat (4) @(negedge clk);
    n_total++;
    if ({quotient, remainder, div_by_zero, done} !== {8'd11, 8'd1, 1'b0, 1'b0})
      $display("FAIL hold_results: got q=%0d r=%0d z=%0b d=%0b expected 11 1 0 0",
               quotient, remainder, div_by_zero, done);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int kd = -1, kb = -1, k2, nb;
    issue(8'd12, 8'd5, 8'd2, 8'd2, 1'b0, 1'b1, 1'b1);
    dividend = 8'd90;
    divisor  = 8'd16;
    sb.push_back(exp_t'{8'd5, 8'd10, 1'b0});
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done && kd < 0) kd = k;
      if (kd >= 0 && busy) begin
        kb = k;
        break;
      end
    end
    start = 1'b0;
    n_total++;
    if (kd !== 8) $display("FAIL b2b_first_latency: got %0d expected 8", kd);
    else n_pass++;
    n_total++;
    if (kb !== 10) $display("FAIL b2b_restart: got %0d expected 10", kb);
    else n_pass++;
    wait_done(k2, nb);
    n_total++;
    if (k2 !== 7) $display("FAIL b2b_second_latency: got %0d expected 7", k2);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    int kd, nb, ndone = 0;
    issue(8'd200, 8'd7, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    n_total++;
    if (busy !== 1'b1) $display("FAIL abort_pre_busy: got %0b expected 1", busy);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0)
      $display("FAIL abort_async_reset: got b=%0b d=%0b q=%0h r=%0h z=%0b expected all 0",
               busy, done, quotient, remainder, div_by_zero);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    n_total++;
    if (ndone !== 0) $display("FAIL abort_no_done: got %0d active cycles expected 0", ndone);
    else n_pass++;
    issue(8'd10, 8'd3, 8'd3, 8'd1, 1'b0, 1'b1, 1'b0);
    wait_done(kd, nb);
    n_total++;
    if (kd !== 8) $display("FAIL abort_recover_latency: got %0d expected 8", kd);
    else n_pass++;
  endtask

  initial begin
    test_reset();
`ifdef SEQ_DIVIDER_SIGNED_EN
    test_signed();
`else
    test_basic();
    test_unsigned_cases();
`endif
    test_div_by_zero();
    test_ignored_start();
    test_back_to_back();
    test_reset_abort();
    repeat (5) @(negedge clk);
    n_total++;
    if (sb.size() !== 0) $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
